// File: rtl/rom_responder.sv
// rom_responder: clocked instruction ROM answering a two-phase (toggle)
// request/response handshake from the fetch stage. The request level is
// synchronised into clk, the word is read after LATENCY wait cycles, and the
// response is signalled by toggling readyOut to match the served request level.
module rom_responder #(
  parameter int    ADDR_WIDTH  = 8,
  parameter int    DATA_WIDTH  = 32,
  parameter int    LATENCY     = 2,
  parameter int    SYNC_STAGES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  triggerIn,
  input  logic [31:0]           addrIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  readyOut,
  output logic                  busyOut,
  output logic                  errOut,
  output logic                  ovfOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    sync_out;
  logic                    par;
  logic                    req;
  logic [31:0]             addr_q;
  logic [3:0]              cnt;
  logic                    addr_oob;
  logic [DATA_WIDTH-1:0]   rom [0:DEPTH-1];

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rom[i] = '0;
    end
  end

  assign sync_out = sync[SYNC_STAGES-1];
  assign req      = sync_out ^ par;
  assign addr_oob = |addr_q[31:ADDR_WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], triggerIn};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      par      <= 1'b0;
      addr_q   <= '0;
      cnt      <= '0;
      dataOut  <= '0;
      readyOut <= 1'b0;
      busyOut  <= 1'b0;
      errOut   <= 1'b0;
      ovfOut   <= 1'b0;
    end else begin
      if (state != IDLE && req) begin
        ovfOut <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addrIn;
            par     <= sync_out;
            cnt     <= 4'(LATENCY);
            busyOut <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            dataOut <= addr_oob ? '0 : rom[addr_q[ADDR_WIDTH-1:0]];
            errOut  <= addr_oob;
            state   <= RESP;
          end
        end
        RESP: begin
          readyOut <= par;
          busyOut  <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_responder.sv
// Testbench for rom_responder: directed handshake scenarios on a default
// instance checked every cycle against an edge-counting transaction model,
// plus two timing-sweep instances checked against hand-computed edges.
`timescale 1ns/1ps
module tb_rom_responder;

    localparam int S = 2;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trig = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data;
    logic        rdy, busy, err, ovf;

    logic        trig2 = 1'b0;
    logic [31:0] addr2 = '0;
    logic [31:0] data_a, data_b;
    logic        rdy_a, busy_a, err_a, ovf_a;
    logic        rdy_b, busy_b, err_b, ovf_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom_m [0:255];

    always #5 clk = ~clk;

    rom_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(L), .SYNC_STAGES(S), .INIT_FILE("")) dut (
        .clk(clk), .rstn(rstn), .triggerIn(trig), .addrIn(addr),
        .dataOut(data), .readyOut(rdy), .busyOut(busy), .errOut(err), .ovfOut(ovf)
    );

    rom_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1), .SYNC_STAGES(3), .INIT_FILE("")) dut_a (
        .clk(clk), .rstn(rstn), .triggerIn(trig2), .addrIn(addr2),
        .dataOut(data_a), .readyOut(rdy_a), .busyOut(busy_a), .errOut(err_a), .ovfOut(ovf_a)
    );

    rom_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(15), .SYNC_STAGES(3), .INIT_FILE("")) dut_b (
        .clk(clk), .rstn(rstn), .triggerIn(trig2), .addrIn(addr2),
        .dataOut(data_b), .readyOut(rdy_b), .busyOut(busy_b), .errOut(err_b), .ovfOut(ovf_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // Edge k counts rising edges since reset release. The synchronised level
    // seen at edge k is triggerIn as sampled at edge k-S. A captured request at
    // edge c yields data at edge c+L and the response at edge c+L+1.
    bit          hist[$];
    int          k;
    bit          m_in, m_par, m_ovf, m_busy, m_rdy, m_err, s_lvl;
    logic [31:0] m_data, m_addr;
    int          m_cap;

    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            hist.delete();
            k = 0; m_in = 0; m_par = 0; m_ovf = 0; m_busy = 0; m_rdy = 0; m_err = 0;
            m_data = '0; m_addr = '0; m_cap = 0;
        end else begin
            s_lvl = (hist.size() >= S) ? hist[hist.size() - S] : 1'b0;
            if (m_in) begin
                if (k == m_cap + L) begin
                    m_err  = (m_addr[31:8] != 24'd0);
                    m_data = m_err ? 32'd0 : rom_m[m_addr[7:0]];
                end
                if (s_lvl != m_par) m_ovf = 1;
                if (k == m_cap + L + 1) begin
                    m_rdy  = m_par;
                    m_busy = 0;
                    m_in   = 0;
                end
            end else if (s_lvl != m_par) begin
                m_in   = 1;
                m_cap  = k;
                m_par  = s_lvl;
                m_addr = addr;
                m_busy = 1;
            end
            hist.push_back(trig);
            k++;
            #1;
            if (rstn) begin
                chk("model dataOut",  data,         m_data);
                chk("model readyOut", 32'(rdy),     32'(m_rdy));
                chk("model busyOut",  32'(busy),    32'(m_busy));
                chk("model errOut",   32'(err),     32'(m_err));
                chk("model ovfOut",   32'(ovf),     32'(m_ovf));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done();
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (rdy === trig && busy === 1'b0) break;
        end
        chk("handshake complete", 32'(rdy), 32'(trig));
    endtask

    task automatic do_req(input logic [31:0] a);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        trig = ~trig;
        wait_done();
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          ea, eb, e1;
        logic [7:0]  b;

        #1;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            rom_m[i] = (i == 3) ? 32'hE3A0_1005 : {8'hA5, b, ~b, b ^ 8'h3C};
            dut.rom[i]   = rom_m[i];
            dut_a.rom[i] = rom_m[i];
            dut_b.rom[i] = rom_m[i];
        end

        // Reset values
        #20;
        chk("rst dataOut",  data,      32'd0);
        chk("rst readyOut", 32'(rdy),  32'd0);
        chk("rst busyOut",  32'(busy), 32'd0);
        chk("rst errOut",   32'(err),  32'd0);
        chk("rst ovfOut",   32'(ovf),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Test 1: first request, response edge E5
        addr = 32'd3;
        @(negedge clk);
        trig = 1'b1;
        e1 = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (rdy === 1'b1 && e1 < 0) e1 = n;
        end
        chk("t1 ready edge", 32'(e1), 32'd5);
        chk("t1 dataOut",    data,    32'hE3A0_1005);
        chk("t1 errOut",     32'(err), 32'd0);

        // Test 2: sequential fetch
        for (int a = 0; a < 4; a++) begin
            do_req(32'(a));
            chk("t2 dataOut", data, rom_m[a]);
            chk("t2 ovfOut",  32'(ovf), 32'd0);
        end

        // Test 3: out-of-range then in-range
        do_req(32'h0000_0100);
        chk("t3 oob dataOut", data, 32'd0);
        chk("t3 oob errOut",  32'(err), 32'd1);
        do_req(32'd1);
        chk("t3 errOut clears", 32'(err), 32'd0);
        chk("t3 dataOut",       data, 32'hA501_FE3D);

        // Test 4: overrun with one extra toggle, then a third toggle
        @(negedge clk);
        addr = 32'd5;
        @(negedge clk);
        trig = ~trig;
        @(negedge clk);
        trig = ~trig;
        repeat (30) @(negedge clk);
        chk("t4 ovfOut",   32'(ovf),  32'd1);
        chk("t4 settled",  32'(rdy),  32'(trig));
        chk("t4 idle",     32'(busy), 32'd0);
        @(negedge clk);
        trig = ~trig;
        wait_done();
        chk("t4 third dataOut", data, rom_m[5]);

        // Test 5: reset during READ with triggerIn held high
        @(negedge clk);
        addr = 32'd7;
        @(negedge clk);
        trig = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t5 busy before reset", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5 rst dataOut",  data,      32'd0);
        chk("t5 rst readyOut", 32'(rdy),  32'd0);
        chk("t5 rst busyOut",  32'(busy), 32'd0);
        chk("t5 rst errOut",   32'(err),  32'd0);
        chk("t5 rst ovfOut",   32'(ovf),  32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_done();
        chk("t5 readyOut", 32'(rdy), 32'd1);
        chk("t5 dataOut",  data,     rom_m[7]);

        // Test 6: latency sweep, SYNC_STAGES=3 with LATENCY=1 and 15
        @(negedge clk);
        addr2 = 32'd9;
        @(negedge clk);
        trig2 = 1'b1;
        ea = -1;
        eb = -1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (rdy_a === 1'b1 && ea < 0) ea = n;
            if (rdy_b === 1'b1 && eb < 0) eb = n;
        end
        chk("t6 L1 ready edge",  32'(ea), 32'd5);
        chk("t6 L15 ready edge", 32'(eb), 32'd19);
        chk("t6 L1 dataOut",     data_a,  32'hA509_F635);
        chk("t6 L15 dataOut",    data_b,  32'hA509_F635);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
